// File: rtl/ascon_inv_sbox_layer_pkg.sv
// Purpose: shared Ascon constants and the inverse-layer FSM state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ascon_inv_sbox_layer_pkg;

  localparam int STATE_W   = 320;
  localparam int WORD_W    = 64;
  localparam int NUM_COLS  = 64;
  localparam int NUM_WORDS = 5;
  localparam int COL_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } layer_state_e;

endpackage

// File: rtl/ascon_inv_sbox.sv
// Purpose: Ascon 5-bit inverse S-box, column value {x0,x1,x2,x3,x4} with x0 as MSB.
// Latency: purely combinational.
// Backpressure: none.
module ascon_inv_sbox
  import ascon_inv_sbox_layer_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  output logic [COL_W-1:0] col_o
);

  // Table lookup of the inverse substitution
  always_comb begin
    col_o = 5'h00;
    case (col_i)
      5'h00: col_o = 5'h14;  5'h01: col_o = 5'h1A;  5'h02: col_o = 5'h07;  5'h03: col_o = 5'h0D;
      5'h04: col_o = 5'h00;  5'h05: col_o = 5'h09;  5'h06: col_o = 5'h0E;  5'h07: col_o = 5'h12;
      5'h08: col_o = 5'h0A;  5'h09: col_o = 5'h06;  5'h0A: col_o = 5'h1D;  5'h0B: col_o = 5'h01;
      5'h0C: col_o = 5'h19;  5'h0D: col_o = 5'h15;  5'h0E: col_o = 5'h13;  5'h0F: col_o = 5'h1E;
      5'h10: col_o = 5'h18;  5'h11: col_o = 5'h16;  5'h12: col_o = 5'h0B;  5'h13: col_o = 5'h11;
      5'h14: col_o = 5'h03;  5'h15: col_o = 5'h05;  5'h16: col_o = 5'h1C;  5'h17: col_o = 5'h1F;
      5'h18: col_o = 5'h17;  5'h19: col_o = 5'h1B;  5'h1A: col_o = 5'h04;  5'h1B: col_o = 5'h08;
      5'h1C: col_o = 5'h0F;  5'h1D: col_o = 5'h0C;  5'h1E: col_o = 5'h10;  5'h1F: col_o = 5'h02;
      default: col_o = 5'h00;
    endcase
  end

endmodule

// File: rtl/ascon_inv_sbox_layer.sv
// Purpose: iterative Ascon inverse substitution layer over a 320-bit state, COLS_PER_CYCLE columns per cycle.
// Latency: out_valid rises 64/COLS_PER_CYCLE cycles after the accepting edge.
// Backpressure: one state in flight; in_ready low in BUSY/DONE, result held in DONE until out_ready.
module ascon_inv_sbox_layer
  import ascon_inv_sbox_layer_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] state_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_out
);

  // Step wraps to 0 for 64 columns per cycle, which is harmless: that config finishes in one cycle.
  localparam logic [5:0] CNT_STEP = 6'(COLS_PER_CYCLE);
  localparam logic [5:0] CNT_LAST = 6'(NUM_COLS - COLS_PER_CYCLE);

  layer_state_e       state_q, state_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [STATE_W-1:0] work_q, work_d;

  logic [WORD_W-1:0]  x_q [NUM_WORDS];
  logic [WORD_W-1:0]  x_d [NUM_WORDS];
  logic [5:0]         col_idx [COLS_PER_CYCLE];
  logic [COL_W-1:0]   col_in  [COLS_PER_CYCLE];
  logic [COL_W-1:0]   col_out [COLS_PER_CYCLE];

  // Split the working register into x0..x4 (x0 is the top word)
  always_comb begin
    for (int j = 0; j < NUM_WORDS; j++) begin
      x_q[j] = work_q[(NUM_WORDS-1-j)*WORD_W +: WORD_W];
    end
  end

  // cnt is always a multiple of the step, so cnt+k never wraps inside one slice
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    assign col_idx[g] = cnt_q + 6'(g);
    assign col_in[g]  = {x_q[0][col_idx[g]], x_q[1][col_idx[g]], x_q[2][col_idx[g]],
                         x_q[3][col_idx[g]], x_q[4][col_idx[g]]};

    ascon_inv_sbox u_inv_sbox (
      .col_i (col_in[g]),
      .col_o (col_out[g])
    );
  end

  // Next-state logic: load in IDLE, substitute a slice in place in BUSY, hold in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    for (int j = 0; j < NUM_WORDS; j++) begin
      x_d[j] = x_q[j];
    end

    if (state_q == ST_BUSY) begin
      for (int k = 0; k < COLS_PER_CYCLE; k++) begin
        x_d[0][col_idx[k]] = col_out[k][4];
        x_d[1][col_idx[k]] = col_out[k][3];
        x_d[2][col_idx[k]] = col_out[k][2];
        x_d[3][col_idx[k]] = col_out[k][1];
        x_d[4][col_idx[k]] = col_out[k][0];
      end
    end

    work_d = '0;
    for (int j = 0; j < NUM_WORDS; j++) begin
      work_d[(NUM_WORDS-1-j)*WORD_W +: WORD_W] = x_d[j];
    end

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = state_in;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CNT_STEP;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // A simultaneous in_valid is deliberately ignored; it is taken in the next IDLE cycle
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and working register; reset drops any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  // Handshake outputs decode directly from the state register
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);
    state_out = work_q;
  end

endmodule

// File: doc/ascon_inv_sbox_layer.md
ASCON_INV_SBOX_LAYER -- requirements
Module: ascon_inv_sbox_layer

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 4, number of 5-bit columns inverted per busy cycle; legal values 1, 2, 4, 8, 16, 32, 64.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  state_in valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a state.
REQ-006 SHALL have port state_in  input  320  packed {x0,x1,x2,x3,x4}; x0 = [319:256], x4 = [63:0].
REQ-007 SHALL have port out_valid  output  1  state_out holds a finished result.
REQ-008 SHALL have port out_ready  input  1  consumer accepts state_out.
REQ-009 SHALL have port state_out  output  320  inverse-substituted state, same packing as state_in.

Function
REQ-010 SHALL form column i (0..63) as {x0[i],x1[i],x2[i],x3[i],x4[i]}, x0 as MSB, and replace it with the Ascon inverse S-box value.
REQ-011 SHALL use the inverse table, indices 0x00..0x1F: 14 1A 07 0D 00 09 0E 12 0A 06 1D 01 19 15 13 1E 18 16 0B 11 03 05 1C 1F 17 1B 04 08 0F 0C 10 02 (hex).
REQ-012 SHALL implement the FSM states IDLE, BUSY and DONE.
REQ-013 SHALL, in IDLE, drive in_ready=1 and out_valid=0.
REQ-014 SHALL, on an edge in IDLE with in_valid=1, register state_in, clear the column counter and enter BUSY.
REQ-015 SHALL, on each BUSY edge, invert columns cnt..cnt+COLS_PER_CYCLE-1 in place and advance cnt by COLS_PER_CYCLE.
REQ-016 SHALL use a 6-bit cnt, starting at column 0 and ascending.
REQ-017 SHALL enter DONE on the BUSY edge that processes column 63, so that out_valid rises exactly 64/COLS_PER_CYCLE cycles after the accepting edge (16 cycles at the default).
REQ-018 SHALL, in DONE, hold out_valid=1 with state_out stable until an edge with out_ready=1, then return to IDLE.
REQ-019 SHALL drive in_ready=0 in BUSY and DONE and ignore in_valid there, so no input is lost or overwritten.
REQ-020 SHALL, when out_ready and in_valid are both high in DONE, complete only the output transfer; the new input is accepted no earlier than the following IDLE cycle.
REQ-021 SHALL have no effect from out_ready outside DONE.
REQ-022 SHALL drive state_out from the working register only; it carries undefined partial data outside DONE, and consumers use it only while out_valid=1.

Reset
REQ-023 SHALL, while rst_n=0 and independent of clk, force state IDLE, cnt=0, the working register to 0, out_valid=0 and in_ready=1 (once rst_n is released).
REQ-024 SHALL, on reset asserted in BUSY or DONE, abort the operation and drop any pending result.
REQ-025 SHALL require a fresh handshake after rst_n is released before any further operation.

Structure
REQ-026 SHALL place in a shared Ascon package: the state width 320, the word width 64, the column count 64, and the FSM state enumeration.
REQ-027 SHALL instantiate COLS_PER_CYCLE copies of one combinational sub-module, ascon_inv_sbox (5-bit in, 5-bit out, table of REQ-011).
REQ-028 SHALL keep ascon_inv_sbox separately unit-testable.

Verification
REQ-029 SHALL cover reset: assert rst_n=0 mid-BUSY -> next cycle out_valid=0, in_ready=1, and no result appears afterwards.
REQ-030 SHALL cover the all-zero state at the default parameter -> after 16 cycles state_out = {64'hFFFFFFFFFFFFFFFF, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 64'h0}.
REQ-031 SHALL cover the all-ones state -> state_out = {64'h0, 64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0}.
REQ-032 SHALL cover round trip: 1000 random states through the forward Ascon S-box layer, then this block, for every legal COLS_PER_CYCLE -> output equals the original state, with latency 64/COLS_PER_CYCLE.
REQ-033 SHALL cover backpressure: out_ready=0 for 10 cycles in DONE while in_valid=1 -> state_out stable, in_ready=0, the second input accepted only after the output handshake.
REQ-034 SHALL cover the ascon_inv_sbox unit test: exhaustive 32 inputs -> output matches REQ-011, and forward(inverse(y)) = y.
